// File: rtl/match_sequencer.sv
// Pong match-level sequencer: keeps both scores, times the pause before each serve,
// hands the serve to the player who lost the point, and declares game-over at WIN_SCORE.
module match_sequencer #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned DELAY_TICKS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       serve,
  output logic       serve_side,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned    CW      = (DELAY_TICKS == 0) ? 1 : $clog2(DELAY_TICKS + 1);
  localparam logic [CW-1:0]  CNT_END = CW'(DELAY_TICKS);
  localparam logic [3:0]     WIN     = 4'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE, DELAY, SERVE, PLAY, POINT, OVER} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          serve_n, serve_side_n, game_over_n, winner_n;
  logic [3:0]    score_l_n, score_r_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      serve      <= 1'b0;
      serve_side <= 1'b0;
      score_l    <= '0;
      score_r    <= '0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      serve      <= serve_n;
      serve_side <= serve_side_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      game_over  <= game_over_n;
      winner     <= winner_n;
    end
  end

  // Outputs are computed as next-state values so every output is a register.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    serve_n      = 1'b0;
    serve_side_n = serve_side;
    score_l_n    = score_l;
    score_r_n    = score_r;
    game_over_n  = game_over;
    winner_n     = winner;
    case (state)
      IDLE: begin
        score_l_n    = '0;
        score_r_n    = '0;
        serve_side_n = 1'b0;
        cnt_n        = '0;
        if (start) state_n = DELAY;
      end
      DELAY: begin
        if (cnt == CNT_END) begin
          cnt_n   = '0;
          state_n = SERVE;
          serve_n = 1'b1;
        end else if (tick) begin
          cnt_n = cnt + CW'(1);
        end
      end
      SERVE: state_n = PLAY;
      PLAY: begin
        if (miss_l && miss_r) begin
          state_n = DELAY;
        end else if (miss_r) begin
          score_l_n    = score_l + 4'd1;
          serve_side_n = 1'b1;
          state_n      = POINT;
        end else if (miss_l) begin
          score_r_n    = score_r + 4'd1;
          serve_side_n = 1'b0;
          state_n      = POINT;
        end
      end
      POINT: begin
        if (score_l == WIN) begin
          state_n     = OVER;
          game_over_n = 1'b1;
          winner_n    = 1'b0;
        end else if (score_r == WIN) begin
          state_n     = OVER;
          game_over_n = 1'b1;
          winner_n    = 1'b1;
        end else begin
          state_n = DELAY;
        end
      end
      OVER: begin
        if (start) begin
          state_n      = DELAY;
          score_l_n    = '0;
          score_r_n    = '0;
          serve_side_n = 1'b0;
          winner_n     = 1'b0;
          game_over_n  = 1'b0;
          cnt_n        = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with WIN_SCORE=3, DELAY_TICKS=2, tick every 4th cycle.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, tick = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic       serve, serve_side, game_over, winner;
  logic [3:0] score_l, score_r;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int serve_cnt = 0;
  int dbl = 0;
  logic tick_now = 1'b0;
  logic prev_serve = 1'b0;

  match_sequencer #(.WIN_SCORE(3), .DELAY_TICKS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .miss_l(miss_l), .miss_r(miss_r), .serve(serve), .serve_side(serve_side),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic step(input logic s, input logic ml, input logic mr);
    start = s; miss_l = ml; miss_r = mr;
    tick_now = (cyc % 4 == 0);
    tick = tick_now;
    cyc++;
    @(posedge clk); #1;
    start = 1'b0; miss_l = 1'b0; miss_r = 1'b0; tick = 1'b0;
    if (serve) begin
      if (prev_serve) dbl++;
      serve_cnt++;
    end
    prev_serve = serve;
  endtask

  // Expect exactly one serve, in the step right after the 2nd counted tick.
  task automatic wait_serve(input int skip, input logic ml_first, input string tag);
    int ticks = 0, t2 = -1, n = 0;
    logic got = 1'b0, early = 1'b0;
    for (int i = 0; i < skip; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (serve) early = 1'b1;
    end
    while (!got && n < 40) begin
      step(1'b0, ml_first && (n == 0), 1'b0);
      n++;
      if (serve) got = 1'b1;
      else if (tick_now) begin
        ticks++;
        if (ticks == 2) t2 = n;
      end
    end
    check({tag, "_early"}, early, 0);
    check({tag, "_got"}, got, 1);
    check({tag, "_lat"}, n, t2 + 1);
    step(1'b0, 1'b0, 1'b0);
    check({tag, "_pulse"}, serve, 0);
  endtask

  initial begin
    int bad;
    int sc;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state and idle behaviour
    check("rst_serve", serve, 0);
    check("rst_side", serve_side, 0);
    check("rst_sl", score_l, 0);
    check("rst_sr", score_r, 0);
    check("rst_over", game_over, 0);
    check("rst_win", winner, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if ({serve, serve_side, score_l, score_r, game_over, winner} !== 11'd0) bad++;
    end
    check("idle_quiet", bad, 0);
    step(1'b0, 1'b0, 1'b1);
    check("idle_miss_sl", score_l, 0);
    check("idle_miss_serve", serve, 0);

    // 2: start leads to one serve after two ticks, left side
    step(1'b1, 1'b0, 1'b0);
    wait_serve(0, 1'b0, "start");
    check("start_side", serve_side, 0);

    // 3: miss_r scores for left, right serves next; miss_l in DELAY ignored
    step(1'b0, 1'b0, 1'b1);
    check("mr_sl", score_l, 1);
    check("mr_sr", score_r, 0);
    check("mr_side", serve_side, 1);
    wait_serve(1, 1'b1, "mr");
    check("delay_ml_sr", score_r, 0);

    // 4: simultaneous misses replay the point
    step(1'b0, 1'b1, 1'b1);
    check("let_sl", score_l, 1);
    check("let_sr", score_r, 0);
    check("let_side", serve_side, 1);
    wait_serve(0, 1'b0, "let");
    check("let_side2", serve_side, 1);

    // 5: right player wins 3-1, then restart
    step(1'b0, 1'b1, 1'b0);
    check("r1_sr", score_r, 1);
    check("r1_side", serve_side, 0);
    wait_serve(1, 1'b0, "r1");
    step(1'b0, 1'b1, 1'b0);
    check("r2_sr", score_r, 2);
    wait_serve(1, 1'b0, "r2");
    step(1'b0, 1'b1, 1'b0);
    check("r3_sr", score_r, 3);
    check("r3_point_over", game_over, 0);
    step(1'b0, 1'b0, 1'b0);
    check("over_flag", game_over, 1);
    check("over_winner", winner, 1);
    check("over_sl", score_l, 1);
    sc = serve_cnt;
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b1);
    check("over_noserve", serve_cnt, sc);
    check("over_hold_sr", score_r, 3);
    check("over_hold_flag", game_over, 1);
    step(1'b1, 1'b0, 1'b0);
    check("restart_sl", score_l, 0);
    check("restart_sr", score_r, 0);
    check("restart_over", game_over, 0);
    check("restart_side", serve_side, 0);
    check("restart_win", winner, 0);
    wait_serve(0, 1'b0, "restart");

    // 6: async reset in DELAY after one counted tick
    step(1'b0, 1'b0, 1'b1);
    check("pre_rst_sl", score_l, 1);
    step(1'b0, 1'b0, 1'b0);
    bad = 1;
    for (int i = 0; i < 8 && bad != 0; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (tick_now) bad = 0;
    end
    check("delay_tick_seen", bad, 0);
    reset = 1'b1;
    #1;
    check("arst_sl", score_l, 0);
    check("arst_side", serve_side, 0);
    check("arst_all", {serve, score_r, game_over, winner}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sc = serve_cnt;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    check("post_rst_noserve", serve_cnt, sc);

    check("no_double_serve", dbl, 0);
    check("serve_total", serve_cnt, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
